// File: rtl/fp32_mul_seq.sv
// rtl/fp32_mul_seq.sv - iterative FP32 multiplier, 24-step shift-add mantissa, truncating
module fp32_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  state_t state, state_n;

  logic               sign_r;
  logic [23:0]        ma, mb;
  logic [47:0]        prod;
  logic [4:0]         cnt;
  logic signed [9:0]  exp_r;

  logic [7:0]  ea, eb;
  logic        a_lo, b_lo, a_inf, b_inf, a_nan, b_nan;
  logic        sign_in, special;
  logic [31:0] special_res;
  logic signed [9:0] exp_in, exp_adj;
  logic [22:0] mant_n;
  logic [31:0] norm_res;

  // Operand classification; denormals share the zero path (flush to zero)
  always_comb begin
    ea      = a[30:23];
    eb      = b[30:23];
    sign_in = a[31] ^ b[31];
    a_lo    = (ea == 8'd0);
    b_lo    = (eb == 8'd0);
    a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
    special = a_lo | b_lo | a_inf | b_inf | a_nan | b_nan;
    exp_in  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (a_nan || b_nan)
      special_res = 32'h7FC00000;
    else if ((a_inf && b_lo) || (b_inf && a_lo))
      special_res = 32'h7FC00000;
    else if (a_inf || b_inf)
      special_res = {sign_in, 8'hFF, 23'd0};
    else
      special_res = {sign_in, 31'd0};
  end

  always_comb begin
    exp_adj = prod[47] ? exp_r + 10'sd1 : exp_r;
    mant_n  = prod[47] ? prod[46:24] : prod[45:23];
    if (exp_adj >= 10'sd255)
      norm_res = {sign_r, 8'hFF, 23'd0};
    else if (exp_adj <= 10'sd0)
      norm_res = {sign_r, 31'd0};
    else
      norm_res = {sign_r, exp_adj[7:0], mant_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = special ? DONE : MUL;
      MUL:  if (cnt == 5'd23) state_n = NORM;
      NORM: state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_r <= 1'b0;
      ma     <= 24'd0;
      mb     <= 24'd0;
      prod   <= 48'd0;
      cnt    <= 5'd0;
      exp_r  <= 10'sd0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_r <= sign_in;
          if (special) begin
            result <= special_res;
          end else begin
            ma    <= {1'b1, a[22:0]};
            mb    <= {1'b1, b[22:0]};
            exp_r <= exp_in;
            prod  <= 48'd0;
            cnt   <= 5'd0;
          end
        end
        MUL: begin
          if (mb[0]) prod <= prod + ({24'd0, ma} << cnt);
          mb  <= mb >> 1;
          cnt <= cnt + 5'd1;
        end
        NORM: result <= norm_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
